// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared types and constants for the register-bus command master.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WA   = 3'd1,
    WD   = 3'd2,
    WB   = 3'd3,
    RA   = 3'd4,
    RD   = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam logic [1:0] BURST_FIXED  = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam int LEN_W   = 8;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
// ============================================================================
// Module  : bus_watchdog
// Brief   : Handshake watchdog; only present when BUS_MASTER_TIMEOUT_EN is set.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef BUS_MASTER_TIMEOUT_EN
module bus_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !active_i || kick_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A handshake in the expiry cycle wins over the timeout.
  assign expire_o = active_i && !kick_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/bus_cmd_master.sv
// ============================================================================
// Module  : bus_cmd_master
// Brief   : Single-outstanding command initiator for the 5-channel register
//           bus. Optional watchdog enabled by BUS_MASTER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_cmd_master
  import bus_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ID_W-1:0]     cmd_id_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [7:0]          cmd_len_i,
  input  logic [1:0]          cmd_burst_i,
  input  logic                wd_valid_i,
  output logic                wd_ready_o,
  input  logic [DATA_W-1:0]   wd_data_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_last_o,
  output logic                done_valid_o,
  input  logic                done_ready_i,
  output logic [1:0]          done_resp_o,
  output logic [ID_W-1:0]     done_id_o,
  output logic [ID_W-1:0]     BUS_WR_ADDR_ID_o,
  output logic [ADDR_W-1:0]   BUS_WR_ADDR_ADDR_o,
  output logic [7:0]          BUS_WR_ADDR_LEN_o,
  output logic [1:0]          BUS_WR_ADDR_BURST_o,
  output logic                BUS_WR_ADDR_VALID_o,
  input  logic                BUS_WR_ADDR_READY_i,
  output logic [DATA_W-1:0]   BUS_WR_DATA_DATA_o,
  output logic [DATA_W/8-1:0] BUS_WR_DATA_STRB_o,
  output logic                BUS_WR_DATA_LAST_o,
  output logic                BUS_WR_DATA_VALID_o,
  input  logic                BUS_WR_DATA_READY_i,
  input  logic [ID_W-1:0]     BUS_WR_BACK_ID_i,
  input  logic [1:0]          BUS_WR_BACK_RESP_i,
  input  logic                BUS_WR_BACK_VALID_i,
  output logic                BUS_WR_BACK_READY_o,
  output logic [ID_W-1:0]     BUS_RD_ADDR_ID_o,
  output logic [ADDR_W-1:0]   BUS_RD_ADDR_ADDR_o,
  output logic [7:0]          BUS_RD_ADDR_LEN_o,
  output logic [1:0]          BUS_RD_ADDR_BURST_o,
  output logic                BUS_RD_ADDR_VALID_o,
  input  logic                BUS_RD_ADDR_READY_i,
  input  logic [ID_W-1:0]     BUS_RD_BACK_ID_i,
  input  logic [DATA_W-1:0]   BUS_RD_DATA_i,
  input  logic [1:0]          BUS_RD_DATA_RESP_i,
  input  logic                BUS_RD_DATA_LAST_i,
  input  logic                BUS_RD_DATA_VALID_i,
  output logic                BUS_RD_DATA_READY_o
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [BURST_W-1:0]  burst_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, beat_last;
  logic timeout;

  assign cmd_hs    = cmd_valid_i && cmd_ready_o;
  assign aw_hs     = BUS_WR_ADDR_VALID_o && BUS_WR_ADDR_READY_i;
  assign w_hs      = BUS_WR_DATA_VALID_o && BUS_WR_DATA_READY_i;
  assign b_hs      = BUS_WR_BACK_VALID_i && BUS_WR_BACK_READY_o;
  assign ar_hs     = BUS_RD_ADDR_VALID_o && BUS_RD_ADDR_READY_i;
  assign r_hs      = BUS_RD_DATA_VALID_i && BUS_RD_DATA_READY_o;
  assign beat_last = (beat_q == len_q);

`ifdef BUS_MASTER_TIMEOUT_EN
  logic wdog_active;
  assign wdog_active = (state_q != IDLE) && (state_q != DONE);

  bus_watchdog #(
    .LIMIT    (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .active_i (wdog_active),
    .kick_i   (aw_hs || w_hs || b_hs || ar_hs || r_hs),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          state_d = cmd_write_i ? WA : RA;
          beat_d  = '0;
          resp_d  = RESP_OKAY;
        end
      end
      WA: if (aw_hs) state_d = WD;
      WD: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (beat_last) begin
            state_d = WB;
            beat_d  = '0;
          end
        end
      end
      WB: begin
        if (b_hs) begin
          state_d = DONE;
          resp_d  = (BUS_WR_BACK_ID_i != id_q) ? RESP_SLVERR : BUS_WR_BACK_RESP_i;
        end
      end
      RA: if (ar_hs) state_d = RD;
      RD: begin
        if (r_hs) begin
          // Protocol disagreements (LAST or ID) are folded in as a slave error.
          resp_d = resp_max(resp_q, BUS_RD_DATA_RESP_i);
          if ((BUS_RD_DATA_LAST_i != beat_last) || (BUS_RD_BACK_ID_i != id_q)) begin
            resp_d = resp_max(resp_d, RESP_SLVERR);
          end
          beat_d = beat_q + 8'd1;
          if (beat_last) begin
            state_d = DONE;
            beat_d  = '0;
          end
        end
      end
      DONE: if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = DONE;
      beat_d  = '0;
      resp_d  = RESP_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      resp_q  <= RESP_OKAY;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
      if (cmd_hs) begin
        id_q    <= cmd_id_i;
        addr_q  <= cmd_addr_i;
        len_q   <= cmd_len_i;
        burst_q <= cmd_burst_i;
      end
    end
  end

  // Held low while rst is asserted so no command is taken during reset.
  assign cmd_ready_o         = (state_q == IDLE) && !rst;

  assign BUS_WR_ADDR_ID_o    = id_q;
  assign BUS_WR_ADDR_ADDR_o  = addr_q;
  assign BUS_WR_ADDR_LEN_o   = len_q;
  assign BUS_WR_ADDR_BURST_o = burst_q;
  assign BUS_WR_ADDR_VALID_o = (state_q == WA);

  assign BUS_WR_DATA_DATA_o  = wd_data_i;
  assign BUS_WR_DATA_STRB_o  = {(DATA_W/8){1'b1}};
  assign BUS_WR_DATA_LAST_o  = beat_last;
  assign BUS_WR_DATA_VALID_o = (state_q == WD) && wd_valid_i;
  assign wd_ready_o          = (state_q == WD) && BUS_WR_DATA_READY_i;

  assign BUS_WR_BACK_READY_o = (state_q == WB);

  assign BUS_RD_ADDR_ID_o    = id_q;
  assign BUS_RD_ADDR_ADDR_o  = addr_q;
  assign BUS_RD_ADDR_LEN_o   = len_q;
  assign BUS_RD_ADDR_BURST_o = burst_q;
  assign BUS_RD_ADDR_VALID_o = (state_q == RA);

  assign rd_valid_o          = (state_q == RD) && BUS_RD_DATA_VALID_i;
  assign BUS_RD_DATA_READY_o = (state_q == RD) && rd_ready_i;
  assign rd_data_o           = BUS_RD_DATA_i;
  assign rd_last_o           = (state_q == RD) && beat_last;

  assign done_valid_o        = (state_q == DONE);
  assign done_resp_o         = resp_q;
  assign done_id_o           = id_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_cmd_master.sv
// ============================================================================
// Module  : tb_bus_cmd_master
// Brief   : Randomized bench with a behavioural bus slave and host model.
//           Timeout scenario runs when BUS_MASTER_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_cmd_master;
  import bus_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_burst;
  logic        wd_valid, wd_ready, rd_valid, rd_ready, rd_last;
  logic [31:0] wd_data, rd_data;
  logic        done_valid, done_ready;
  logic [1:0]  done_resp;
  logic [3:0]  done_id;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

  bus_cmd_master #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_burst_i(cmd_burst),
    .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_resp_o(done_resp),
    .done_id_o(done_id),
    .BUS_WR_ADDR_ID_o(aw_id), .BUS_WR_ADDR_ADDR_o(aw_addr), .BUS_WR_ADDR_LEN_o(aw_len),
    .BUS_WR_ADDR_BURST_o(aw_burst), .BUS_WR_ADDR_VALID_o(aw_valid),
    .BUS_WR_ADDR_READY_i(aw_ready),
    .BUS_WR_DATA_DATA_o(w_data), .BUS_WR_DATA_STRB_o(w_strb), .BUS_WR_DATA_LAST_o(w_last),
    .BUS_WR_DATA_VALID_o(w_valid), .BUS_WR_DATA_READY_i(w_ready),
    .BUS_WR_BACK_ID_i(b_id), .BUS_WR_BACK_RESP_i(b_resp), .BUS_WR_BACK_VALID_i(b_valid),
    .BUS_WR_BACK_READY_o(b_ready),
    .BUS_RD_ADDR_ID_o(ar_id), .BUS_RD_ADDR_ADDR_o(ar_addr), .BUS_RD_ADDR_LEN_o(ar_len),
    .BUS_RD_ADDR_BURST_o(ar_burst), .BUS_RD_ADDR_VALID_o(ar_valid),
    .BUS_RD_ADDR_READY_i(ar_ready),
    .BUS_RD_BACK_ID_i(r_id), .BUS_RD_DATA_i(r_data), .BUS_RD_DATA_RESP_i(r_resp),
    .BUS_RD_DATA_LAST_i(r_last), .BUS_RD_DATA_VALID_i(r_valid),
    .BUS_RD_DATA_READY_o(r_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem     [0:31];
  logic [31:0] host_wd [0:255];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit coin(input int stall_pct);
    return $urandom_range(0, 99) >= stall_pct;
  endfunction

  function automatic logic [4:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
    logic [31:0] s;
    s = (b == BURST_FIXED) ? a : a + 32'(i);
    return s[4:0];
  endfunction

  task automatic clear_inputs();
    cmd_valid = 0; wd_valid = 0; rd_ready = 0; done_ready = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
  endtask

  // One complete command with the bench acting as host and slave. Starts and ends at a negedge.
  task automatic run_txn(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, input int stall,
                         input bit hold_done, input bit bad_id, input bit bad_last);
    bit err, fin, fin_prev, seen_done, busy_ready, b_pend, b_got, ar_done;
    logic [1:0]  exp_resp;
    logic [31:0] rexp;
    int wsent, rsent, done_wait, w;
    err = (addr >= 32) || (burst > BURST_INCR) ||
          (burst == BURST_INCR && addr + 32'(len) >= 32);
    exp_resp = (err || (wr && bad_id) || (!wr && bad_last)) ? RESP_SLVERR : RESP_OKAY;
    fin = 0; fin_prev = 0; seen_done = 0; busy_ready = 0; b_pend = 0; b_got = 0; ar_done = 0;
    wsent = 0; rsent = 0; done_wait = 0;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check_val("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_burst = burst;
    @(negedge clk);
    cmd_valid = 0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      aw_ready = coin(stall); w_ready = coin(stall); ar_ready = coin(stall);
      b_valid  = b_pend && coin(stall);
      b_id     = bad_id ? ~id : id;
      b_resp   = err ? RESP_SLVERR : RESP_OKAY;
      rexp     = err ? 32'hFFFF_FFFF : mem[beat_addr(addr, burst, rsent)];
      r_valid  = ar_done && (rsent <= int'(len)) && coin(stall);
      r_id     = id;
      r_data   = rexp;
      r_resp   = err ? RESP_SLVERR : RESP_OKAY;
      r_last   = (rsent == int'(len)) ^ (bad_last && rsent == 0);
      wd_valid = (wsent <= int'(len)) && coin(stall);
      wd_data  = (wsent <= int'(len)) ? host_wd[wsent] : 32'h0;
      rd_ready = coin(stall);
      done_ready = hold_done ? (done_wait >= 20) : coin(stall);
      #1;
      if (cyc == 0) check_val("addr_latency", wr ? aw_valid : ar_valid, 1);
      if (fin_prev) check_val("done_latency", done_valid, 1);
      fin_prev = 0;
      if (cmd_ready) busy_ready = 1;
      if (aw_valid) begin
        check_val("wr_addr_fields", {aw_id, aw_addr, aw_len, aw_burst}, {id, addr, len, burst});
        if (aw_ready) ar_done = ar_done;
      end
      if (ar_valid) begin
        check_val("rd_addr_fields", {ar_id, ar_addr, ar_len, ar_burst}, {id, addr, len, burst});
        if (ar_ready) ar_done = 1;
      end
      if ((w_valid && w_ready) || (wd_valid && wd_ready)) begin
        check_val("wr_pass", {w_valid && w_ready, wd_valid && wd_ready}, 2'b11);
        check_val("wr_beat", {w_data, w_strb, w_last},
                  {(wsent <= int'(len)) ? host_wd[wsent] : 32'h0, 4'hF, wsent == int'(len)});
        if (!err) mem[beat_addr(addr, burst, wsent)] = w_data;
        if (wsent == int'(len)) b_pend = 1;
        wsent++;
      end
      if (b_valid && b_ready) begin b_pend = 0; b_got = 1; fin_prev = 1; end
      if ((r_valid && r_ready) || (rd_valid && rd_ready)) begin
        check_val("rd_pass", {r_valid && r_ready, rd_valid && rd_ready}, 2'b11);
        check_val("rd_beat", {rd_data, rd_last}, {rexp, rsent == int'(len)});
        if (rsent == int'(len)) fin_prev = 1;
        rsent++;
      end
      if (done_valid) begin
        if (!seen_done) check_val("done_not_early", wr ? b_got : (rsent > int'(len)), 1);
        seen_done = 1;
        check_val("done_fields", {done_resp, done_id}, {exp_resp, id});
        if (done_ready) fin = 1; else done_wait++;
      end
      @(negedge clk);
    end
    check_val("txn_complete", fin, 1);
    check_val("cmd_ready_while_busy", busy_ready, 0);
    clear_inputs();
    check_val("back_to_back_ready", cmd_ready, 1);
  endtask

  task automatic reset_mid_write();
    bit saw_done;
    for (int i = 0; i < 4; i++) host_wd[i] = 32'h5500 + 32'(i);
    cmd_valid = 1; cmd_write = 1; cmd_id = 4'd5; cmd_addr = 0; cmd_len = 3; cmd_burst = BURST_INCR;
    @(negedge clk);
    cmd_valid = 0; aw_ready = 1; w_ready = 1; wd_valid = 1; wd_data = host_wd[0];
    @(negedge clk);
    wd_data = host_wd[0];
    @(negedge clk);
    wd_data = host_wd[1];
    check_val("rst_pre_beat2", {w_valid, w_last}, 2'b10);
    rst = 1;
    @(negedge clk);
    check_val("rst_outputs_low",
              {cmd_ready, aw_valid, w_valid, wd_ready, b_ready, ar_valid, r_ready, rd_valid, done_valid},
              9'b0);
    rst = 0;
    clear_inputs();
    #1;
    check_val("rst_cmd_ready_after", cmd_ready, 1);
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_valid) saw_done = 1;
    end
    check_val("rst_no_done", saw_done, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] addr;
    clear_inputs();
    cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0;
    wd_data = 0; b_id = 0; b_resp = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1;
    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              {cmd_ready, aw_valid, w_valid, wd_ready, b_ready, ar_valid, r_ready, rd_valid, done_valid},
              9'b0);
    rst = 0;
    @(negedge clk);
    check_val("reset_release_ready", cmd_ready, 1);

    // Single-beat write
    host_wd[0] = 32'h1;
    run_txn(1, 4'd3, 32'h09, 8'd0, BURST_INCR, 0, 0, 0, 0);
    // Incr burst write then read back
    host_wd[0] = 32'hA; host_wd[1] = 32'hB; host_wd[2] = 32'hC; host_wd[3] = 32'hD;
    run_txn(1, 4'd1, 32'h01, 8'd3, BURST_INCR, 0, 0, 0, 0);
    run_txn(0, 4'd2, 32'h01, 8'd3, BURST_INCR, 0, 0, 0, 0);
    check_val("mem_readback", {mem[1], mem[2], mem[3], mem[4]},
              {32'hA, 32'hB, 32'hC, 32'hD});
    // Error paths
    run_txn(0, 4'd4, 32'h20, 8'd1, BURST_INCR, 0, 0, 0, 0);
    run_txn(1, 4'd6, 32'h00, 8'd1, 2'b10, 0, 0, 0, 0);
    host_wd[0] = 32'h77;
    run_txn(1, 4'd7, 32'h02, 8'd0, BURST_FIXED, 20, 0, 1, 0);
    run_txn(0, 4'd8, 32'h02, 8'd2, BURST_INCR, 20, 0, 0, 1);
    // Randomized stalls, including long done back-pressure
    for (int t = 0; t < 24; t++) begin
      len   = 8'($urandom_range(0, 7));
      burst = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 9) == 0) ? 32'h20 : 32'($urandom_range(0, 31 - int'(len)));
      for (int i = 0; i <= int'(len); i++) host_wd[i] = $urandom;
      run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, len, burst,
              40, (t % 8 == 3), 0, 0);
    end
    // Maximum length bursts
    for (int i = 0; i < 256; i++) host_wd[i] = $urandom;
    run_txn(1, 4'd9, 32'h05, 8'd255, BURST_FIXED, 10, 0, 0, 0);
    check_val("len255_fixed_mem", mem[5], host_wd[255]);
    run_txn(0, 4'd10, 32'h05, 8'd255, BURST_FIXED, 10, 0, 0, 0);

    reset_mid_write();

`ifdef BUS_MASTER_TIMEOUT_EN
    begin
      int k;
      cmd_valid = 1; cmd_write = 1; cmd_id = 4'd11; cmd_addr = 0; cmd_len = 0;
      cmd_burst = BURST_INCR;
      @(negedge clk);
      cmd_valid = 0;
      k = 0;
      while (!done_valid && k < 100) begin @(negedge clk); k++; end
      check_val("timeout_cycles", 64'(k), 64'(TO));
      check_val("timeout_resp", {done_resp, done_id, aw_valid, w_valid}, {RESP_TIMEOUT, 4'd11, 2'b00});
      done_ready = 1;
      @(negedge clk);
      done_ready = 0;
      check_val("timeout_idle", cmd_ready, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
